ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width (256 locations).
REQ-002 SHALL have parameter DATA_W, default 8, memory word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive fetch denials before fetch is forced to win.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports if_req in 1 and if_addr in ADDR_W, the instruction-fetch read request and its address.
REQ-007 SHALL have ports if_gnt out 1, if_rvalid out 1 and if_rdata out DATA_W, the fetch grant, read-data valid and read data.
REQ-008 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W and d_wdata in DATA_W, the data-port request, write enable, address and write data.
REQ-009 SHALL have ports d_gnt out 1, d_rvalid out 1 and d_rdata out DATA_W, the data-port grant, read-data valid and read data.
REQ-010 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W and mem_wdata out DATA_W, driving a single-port synchronous memory.
REQ-011 SHALL have port mem_rdata  in  DATA_W  memory read data, valid one cycle after a read with mem_en=1.

Function
REQ-012 SHALL grant at most one port per cycle; if_gnt and d_gnt are combinational from requests and registered state, never both 1.
REQ-013 SHALL, with only one request active, grant that request in the same cycle.
REQ-014 SHALL, with both requests active, grant data unless starve_cnt==STARVE_LIMIT, in which case grant fetch.
REQ-015 SHALL increment starve_cnt on if_req=1 and if_gnt=0, saturating at STARVE_LIMIT; clear it on if_gnt=1 or if_req=0.
REQ-016 SHALL set mem_en=1 in exactly the cycles where a grant is issued; mem_en=0 otherwise.
REQ-017 SHALL drive mem_addr/mem_we/mem_wdata from the granted port: fetch -> if_addr, we=0, wdata=0; data -> d_addr, d_we, d_wdata.
REQ-018 SHALL drive mem_addr=0, mem_we=0 and mem_wdata=0 when no grant is issued.
REQ-019 SHALL register a pending-read tag per cycle; if_rvalid=1 the cycle after a fetch grant, d_rvalid=1 the cycle after a data grant with d_we=0.
REQ-020 SHALL never assert d_rvalid for a write grant; the write is committed in the grant cycle.
REQ-021 SHALL drive if_rdata and d_rdata equal to mem_rdata while the respective rvalid is 1 and hold the last delivered value otherwise.
REQ-022 SHALL support back-to-back grants every cycle with read latency exactly 1 cycle and no bubble.
REQ-023 SHALL require each requester to hold req/addr/we/wdata stable until its grant; a request withdrawn before grant is dropped with no side effect.
REQ-024 SHALL have address wrap handled by the memory; the arbiter performs no address arithmetic.

Reset
REQ-025 SHALL, while rst_n=0, force all outputs to 0, starve_cnt=0, pending-read tags cleared and held rdata registers cleared.
REQ-026 SHALL discard any read granted in the cycle reset asserts: no rvalid after rst_n deasserts for it.
REQ-027 SHALL resume arbitration on the first rising edge with rst_n=1.

Verification
REQ-028 SHALL test fetch-only: if_req=1, if_addr=0x00, mem holds 0x01 -> if_gnt same cycle, if_rvalid=1 and if_rdata=0x01 next cycle.
REQ-029 SHALL test collision: both req, d_we=1, d_addr=0x10, d_wdata=0xA5 -> d_gnt=1, mem_we=1, mem_addr=0x10, if_gnt=0, no d_rvalid.
REQ-030 SHALL test starvation: both req held 6 cycles -> d_gnt cycles 1-4, if_gnt cycle 5, starve_cnt=0 after, d_gnt cycle 6.
REQ-031 SHALL test streaming: fetch reads 0x00..0x03 consecutively -> 4 grants in 4 cycles, rvalid in 4 consecutive cycles, data in order.
REQ-032 SHALL test mid-read reset: rst_n=0 in the cycle of a fetch grant -> all outputs 0, no if_rvalid after release.
REQ-033 SHALL test withdrawal: if_req high 2 denied cycles then low -> starve_cnt returns to 0, no fetch access issued.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates an instruction-fetch port and a data port onto one
//   single-port synchronous RAM. Grants are combinational (same cycle),
//   read data returns exactly one cycle after its grant; writes commit in the
//   grant cycle. No internal queueing: an ungranted requester simply waits.
// Ports:
//   clk, rst_n                         - clock, async active-low reset
//   if_req/if_addr                     - fetch read request and address
//   if_gnt/if_rvalid/if_rdata          - fetch grant, read-data valid, data
//   d_req/d_we/d_addr/d_wdata          - data-port request (read or write)
//   d_gnt/d_rvalid/d_rdata             - data-port grant, read valid, data
//   mem_en/mem_we/mem_addr/mem_wdata   - command to the single-port RAM
//   mem_rdata                          - RAM read data (1-cycle latency)
module ram_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  // Number of consecutive cycles fetch has been requesting without a grant.
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  // One-cycle pending-read tags: which port owns the data on mem_rdata.
  logic             if_rd_pend;
  logic             d_rd_pend;

  // Last delivered read data per port, held between deliveries.
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // ---------------------------------------------------------------------------
  // Grant logic. Data has priority on a collision unless fetch has been denied
  // STARVE_LIMIT times in a row. Grants are gated by rst_n so that every output
  // reads zero for the whole time reset is held, including a grant that would
  // otherwise appear in the cycle reset asserts.
  // ---------------------------------------------------------------------------
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if (d_req && !(if_req && starved)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory command mux: idle cycles drive an all-zero command.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts denied fetch cycles, saturating at the limit.
  // A grant or a withdrawn request restarts the count, so a requester that
  // gives up leaves no lingering priority behind.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (!starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-read tags. Writes never produce a response. Because the tags are
  // cleared asynchronously, a read granted in the cycle reset asserts never
  // surfaces as an rvalid afterwards.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rd_pend <= 1'b0;
      d_rd_pend  <= 1'b0;
    end else begin
      if_rd_pend <= if_gnt;
      d_rd_pend  <= d_gnt & ~d_we;
    end
  end

  assign if_rvalid = if_rd_pend;
  assign d_rvalid  = d_rd_pend;

  // ---------------------------------------------------------------------------
  // Read data: pass mem_rdata straight through in the delivery cycle, and
  // capture it so the port keeps showing its last value afterwards even when
  // the RAM output moves on to serve the other port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_rd_pend) begin
        if_rdata_q <= mem_rdata;
      end
      if (d_rd_pend) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign if_rdata = if_rd_pend ? mem_rdata : if_rdata_q;
  assign d_rdata  = d_rd_pend  ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter with a behavioural
//   single-port synchronous RAM and a reference copy of its contents.
//   Expected read data is queued per port at grant time and checked on rvalid.
module tb_ram_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LIMIT  = 4;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DATA_W-1:0] mem     [256];
  logic [DATA_W-1:0] ref_mem [256];
  logic [DATA_W-1:0] if_exp [$];
  logic [DATA_W-1:0] d_exp  [$];
  logic [DATA_W-1:0] mon_if_v;
  logic [DATA_W-1:0] mon_d_v;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port synchronous RAM.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Scoreboard monitor: every rvalid pops and checks one expected word.
  always @(negedge clk) begin
    if (if_rvalid) begin
      total_cnt++;
      if (if_exp.size() == 0) begin
        $display("FAIL if_unexpected_rvalid: got rvalid with data %h, expected none", if_rdata);
      end else begin
        mon_if_v = if_exp.pop_front();
        if (if_rdata !== mon_if_v)
          $display("FAIL if_rdata_sb: got %h expected %h", if_rdata, mon_if_v);
        else pass_cnt++;
      end
    end
    if (d_rvalid) begin
      total_cnt++;
      if (d_exp.size() == 0) begin
        $display("FAIL d_unexpected_rvalid: got rvalid with data %h, expected none", d_rdata);
      end else begin
        mon_d_v = d_exp.pop_front();
        if (d_rdata !== mon_d_v)
          $display("FAIL d_rdata_sb: got %h expected %h", d_rdata, mon_d_v);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic ir, input logic [7:0] ia, input logic dr,
                       input logic dw, input logic [7:0] da, input logic [7:0] dd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 8'h33);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total_cnt++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we});
    else pass_cnt++;
    total_cnt++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 32'h0)
      $display("FAIL reset_data: got %h expected 00000000", {if_rdata, d_rdata, mem_addr, mem_wdata});
    else pass_cnt++;
    total_cnt++;
    if (int'(dut.starve_cnt) !== 0)
      $display("FAIL reset_starve: got %0d expected 0", dut.starve_cnt);
    else pass_cnt++;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_only;
    @(negedge clk);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    total_cnt++;
    if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b1010)
      $display("FAIL fetch_gnt: got %b expected 1010", {if_gnt, d_gnt, mem_en, mem_we});
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 8'h00)
      $display("FAIL fetch_addr: got %h expected 00", mem_addr);
    else pass_cnt++;
    if_exp.push_back(ref_mem[0]);
    @(posedge clk); #1;
    total_cnt++;
    if (if_rvalid !== 1'b1 || if_rdata !== 8'h01)
      $display("FAIL fetch_rdata: got v=%b d=%h expected v=1 d=01", if_rvalid, if_rdata);
    else pass_cnt++;
    // Data read of another word moves mem_rdata; fetch data must hold.
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
    d_exp.push_back(ref_mem[8'h40]);
    @(posedge clk); #1;
    total_cnt++;
    if (if_rvalid !== 1'b0 || if_rdata !== 8'h01 || d_rvalid !== 1'b1)
      $display("FAIL fetch_hold: got iv=%b id=%h dv=%b expected iv=0 id=01 dv=1", if_rvalid, if_rdata, d_rvalid);
    else pass_cnt++;
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    total_cnt++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== 18'h0)
      $display("FAIL idle_cmd: got en=%b we=%b a=%h wd=%h expected all 0", mem_en, mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
  endtask

  task automatic test_collision;
    @(negedge clk);
    drive(1'b1, 8'h05, 1'b1, 1'b1, 8'h10, 8'hA5);
    #1;
    total_cnt++;
    if ({d_gnt, if_gnt, mem_en, mem_we} !== 4'b1011)
      $display("FAIL coll_gnt: got %b expected 1011", {d_gnt, if_gnt, mem_en, mem_we});
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 8'h10 || mem_wdata !== 8'hA5)
      $display("FAIL coll_cmd: got a=%h wd=%h expected a=10 wd=a5", mem_addr, mem_wdata);
    else pass_cnt++;
    ref_mem[8'h10] = 8'hA5;
    @(posedge clk); #1;
    total_cnt++;
    if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0)
      $display("FAIL coll_no_rvalid: got dv=%b iv=%b expected 0 0", d_rvalid, if_rvalid);
    else pass_cnt++;
    // Read the written word back through the data port.
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    d_exp.push_back(ref_mem[8'h10]);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_starvation;
    int  st;
    logic exp_if;
    st = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      drive(1'b1, 8'h30, 1'b1, 1'b0, 8'h20, 8'h00);
      #1;
      exp_if = (st == LIMIT);
      total_cnt++;
      if (if_gnt !== exp_if || d_gnt !== !exp_if)
        $display("FAIL starve_gnt_c%0d: got if=%b d=%b expected if=%b d=%b", k, if_gnt, d_gnt, exp_if, !exp_if);
      else pass_cnt++;
      if (exp_if) if_exp.push_back(ref_mem[8'h30]);
      else        d_exp.push_back(ref_mem[8'h20]);
      st = exp_if ? 0 : ((st < LIMIT) ? st + 1 : LIMIT);
      @(posedge clk); #1;
      total_cnt++;
      if (int'(dut.starve_cnt) !== st)
        $display("FAIL starve_cnt_c%0d: got %0d expected %0d", k, dut.starve_cnt, st);
      else pass_cnt++;
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_streaming;
    logic [7:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 8'(i);
      @(negedge clk);
      drive(1'b1, a, 1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      total_cnt++;
      if (if_gnt !== 1'b1 || mem_addr !== a)
        $display("FAIL stream_gnt_%0d: got g=%b a=%h expected g=1 a=%h", i, if_gnt, mem_addr, a);
      else pass_cnt++;
      if_exp.push_back(ref_mem[a]);
      @(posedge clk); #1;
      total_cnt++;
      if (if_rvalid !== 1'b1)
        $display("FAIL stream_rvalid_%0d: got %b expected 1", i, if_rvalid);
      else pass_cnt++;
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    total_cnt++;
    if (if_rvalid !== 1'b0)
      $display("FAIL stream_end: got rvalid %b expected 0", if_rvalid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read;
    @(negedge clk);
    drive(1'b1, 8'h07, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    total_cnt++;
    if (if_gnt !== 1'b1)
      $display("FAIL midrst_pre_gnt: got %b expected 1", if_gnt);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, if_rdata, d_rdata, mem_addr, mem_wdata} !== 38'h0)
      $display("FAIL midrst_outputs: got g=%b%b v=%b%b en=%b we=%b ird=%h drd=%h a=%h wd=%h expected all 0",
               if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, if_rdata, d_rdata, mem_addr, mem_wdata);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (if_rvalid !== 1'b0)
        $display("FAIL midrst_no_rvalid_%0d: got %b expected 0", i, if_rvalid);
      else pass_cnt++;
    end
  endtask

  task automatic test_withdrawal;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b1, 8'h50, 1'b1, 1'b0, 8'h60, 8'h00);
      #1;
      total_cnt++;
      if (if_gnt !== 1'b0 || d_gnt !== 1'b1)
        $display("FAIL wd_gnt_%0d: got if=%b d=%b expected if=0 d=1", k, if_gnt, d_gnt);
      else pass_cnt++;
      d_exp.push_back(ref_mem[8'h60]);
      @(posedge clk); #1;
      total_cnt++;
      if (int'(dut.starve_cnt) !== k + 1)
        $display("FAIL wd_starve_%0d: got %0d expected %0d", k, dut.starve_cnt, k + 1);
      else pass_cnt++;
    end
    @(negedge clk);
    drive(1'b0, 8'h50, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    total_cnt++;
    if (if_gnt !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL wd_drop: got g=%b en=%b expected 0 0", if_gnt, mem_en);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (int'(dut.starve_cnt) !== 0 || if_rvalid !== 1'b0)
      $display("FAIL wd_clear: got cnt=%0d iv=%b expected 0 0", dut.starve_cnt, if_rvalid);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i + 1);
      ref_mem[i] = 8'(i + 1);
    end
    mem_rdata = '0;
    test_reset;
    test_fetch_only;
    test_collision;
    test_starvation;
    test_streaming;
    test_reset_mid_read;
    test_withdrawal;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total_cnt++;
    if (if_exp.size() != 0 || d_exp.size() != 0)
      $display("FAIL sb_drain: got %0d/%0d outstanding expected 0/0", if_exp.size(), d_exp.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
